// File: rtl/cook_timer.sv
// BCD MM:SS countdown timer: keypad shift-in entry, one-second countdown while the
// magnetron is on, and a level done flag that stays up until clear, load or reset.
module cook_timer #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clearn,
  input  logic       load,
  input  logic [3:0] digit_in,
  input  logic       magnetron_on,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       zero,
  output logic       timer_done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    SETUP    = 2'd0,
    COUNTING = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t        r_state, w_nstate;
  logic [PW-1:0] r_presc, w_npresc;
  logic [3:0]    r_so, r_st, r_mo, r_mt;
  logic [3:0]    w_nso, w_nst, w_nmo, w_nmt;
  logic [3:0]    w_dso, w_dst, w_dmo, w_dmt;
  logic          r_done, w_ndone;
  logic          w_zero, w_dec_zero, w_dig_ok;

  assign w_zero     = (r_so == 4'd0) && (r_st == 4'd0) && (r_mo == 4'd0) && (r_mt == 4'd0);
  assign w_dig_ok   = load && (digit_in <= 4'd9);
  assign w_dec_zero = (w_dso == 4'd0) && (w_dst == 4'd0) && (w_dmo == 4'd0) && (w_dmt == 4'd0);

  // One-step BCD decrement; seconds above 59 are decremented as-is, never wraps below 00:00.
  always_comb begin
    w_dso = r_so;
    w_dst = r_st;
    w_dmo = r_mo;
    w_dmt = r_mt;
    if ((r_so != 4'd0) || (r_st != 4'd0)) begin
      if (r_so != 4'd0) begin
        w_dso = r_so - 4'd1;
      end else begin
        w_dso = 4'd9;
        w_dst = r_st - 4'd1;
      end
    end else if ((r_mo != 4'd0) || (r_mt != 4'd0)) begin
      w_dso = 4'd9;
      w_dst = 4'd5;
      if (r_mo != 4'd0) begin
        w_dmo = r_mo - 4'd1;
      end else begin
        w_dmo = 4'd9;
        w_dmt = r_mt - 4'd1;
      end
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_npresc = r_presc;
    w_nso    = r_so;
    w_nst    = r_st;
    w_nmo    = r_mo;
    w_nmt    = r_mt;
    w_ndone  = r_done;
    case (r_state)
      SETUP: begin
        if (w_dig_ok) begin
          w_nmt = r_mo;
          w_nmo = r_st;
          w_nst = r_so;
          w_nso = digit_in;
        end
        if (magnetron_on && !w_zero) begin
          w_nstate = COUNTING;
          w_npresc = '0;
        end
      end
      COUNTING: begin
        if (!magnetron_on) begin
          w_nstate = SETUP;
          w_npresc = '0;
        end else if (r_presc == PRESC_LAST) begin
          w_npresc = '0;
          w_nso    = w_dso;
          w_nst    = w_dst;
          w_nmo    = w_dmo;
          w_nmt    = w_dmt;
          if (w_dec_zero) begin
            w_nstate = DONE;
            w_ndone  = 1'b1;
          end
        end else begin
          w_npresc = r_presc + PW'(1);
        end
      end
      DONE: begin
        if (w_dig_ok) begin
          w_nmt    = 4'd0;
          w_nmo    = 4'd0;
          w_nst    = 4'd0;
          w_nso    = digit_in;
          w_ndone  = 1'b0;
          w_nstate = SETUP;
        end
      end
      default: begin
        w_nstate = SETUP;
        w_npresc = '0;
        w_ndone  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !clearn) begin
      r_state <= SETUP;
      r_presc <= '0;
      r_so    <= '0;
      r_st    <= '0;
      r_mo    <= '0;
      r_mt    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_presc <= w_npresc;
      r_so    <= w_nso;
      r_st    <= w_nst;
      r_mo    <= w_nmo;
      r_mt    <= w_nmt;
      r_done  <= w_ndone;
    end
  end

  assign sec_ones   = r_so;
  assign sec_tens   = r_st;
  assign min_ones   = r_mo;
  assign min_tens   = r_mt;
  assign zero       = w_zero;
  assign timer_done = r_done;

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with TICK_DIV=4; expected MM:SS values are hand-computed.
module tb_cook_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clearn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       magnetron_on = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       zero, timer_done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  cook_timer #(.TICK_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .clearn       (clearn),
    .load         (load),
    .digit_in     (digit_in),
    .magnetron_on (magnetron_on),
    .sec_ones     (sec_ones),
    .sec_tens     (sec_tens),
    .min_ones     (min_ones),
    .min_tens     (min_tens),
    .zero         (zero),
    .timer_done   (timer_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    load = 1'b1;
    digit_in = d;
    step(1);
    load = 1'b0;
  endtask

  task automatic do_clear();
    magnetron_on = 1'b0;
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
  endtask

  function automatic logic [15:0] val();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    // reset
    step(2);
    check("rst_val", 32'(val()), 32'h0000);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_done", 32'(timer_done), 32'd0);
    rst = 1'b0;

    // entry
    key(4'd1); key(4'd3); key(4'd0);
    check("entry_130", 32'(val()), 32'h0130);
    check("entry_zero", 32'(zero), 32'd0);
    key(4'd12);
    check("entry_ignore12", 32'(val()), 32'h0130);
    key(4'd5); key(4'd5); key(4'd5); key(4'd5); key(4'd7);
    check("entry_5557", 32'(val()), 32'h5557);

    // countdown from 00:03
    do_clear();
    check("clear_val", 32'(val()), 32'h0000);
    key(4'd3);
    magnetron_on = 1'b1;
    step(1);
    step(3);
    check("cd_before_tick", 32'(val()), 32'h0003);
    step(1);
    check("cd_cyc4", 32'(val()), 32'h0002);
    step(4);
    check("cd_cyc8", 32'(val()), 32'h0001);
    check("cd_done_early", 32'(timer_done), 32'd0);
    step(4);
    check("cd_cyc12", 32'(val()), 32'h0000);
    check("cd_done", 32'(timer_done), 32'd1);
    magnetron_on = 1'b0;
    step(3);
    check("cd_done_hold", 32'(timer_done), 32'd1);
    check("cd_hold_val", 32'(val()), 32'h0000);
    do_clear();
    check("cd_done_cleared", 32'(timer_done), 32'd0);

    // borrows: enter, 4 more edges to the tick, then pause
    key(4'd1); key(4'd0); key(4'd0);
    magnetron_on = 1'b1; step(5); magnetron_on = 1'b0; step(1);
    check("borrow_0100", 32'(val()), 32'h0059);
    do_clear();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    magnetron_on = 1'b1; step(5); magnetron_on = 1'b0; step(1);
    check("borrow_1000", 32'(val()), 32'h0959);
    do_clear();
    key(4'd1); key(4'd9); key(4'd9);
    magnetron_on = 1'b1; step(5); magnetron_on = 1'b0; step(1);
    check("borrow_0199", 32'(val()), 32'h0198);

    // pause, ignored load, resume
    do_clear();
    key(4'd2); key(4'd0);
    magnetron_on = 1'b1;
    step(2);
    key(4'd7);
    check("load_in_counting", 32'(val()), 32'h0020);
    magnetron_on = 1'b0;
    step(1);
    check("pause_held", 32'(val()), 32'h0020);
    step(3);
    check("pause_held_long", 32'(val()), 32'h0020);
    magnetron_on = 1'b1;
    step(4);
    check("resume_no_early", 32'(val()), 32'h0020);
    step(1);
    check("resume_tick", 32'(val()), 32'h0019);

    // enable drops exactly on a tick edge
    step(3);
    magnetron_on = 1'b0;
    step(1);
    check("drop_on_tick", 32'(val()), 32'h0019);
    magnetron_on = 1'b1;
    step(5);
    check("after_drop_tick", 32'(val()), 32'h0018);

    // load while DONE
    do_clear();
    key(4'd1);
    magnetron_on = 1'b1;
    step(5);
    check("done2_val", 32'(val()), 32'h0000);
    check("done2_flag", 32'(timer_done), 32'd1);
    key(4'd4);
    check("load_in_done_val", 32'(val()), 32'h0004);
    check("load_in_done_flag", 32'(timer_done), 32'd0);
    magnetron_on = 1'b0;
    step(1);

    // clearn during COUNTING at 00:05, then enable with zero stays idle
    do_clear();
    key(4'd5);
    magnetron_on = 1'b1;
    step(2);
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
    check("clearn_mid", 32'(val()), 32'h0000);
    step(6);
    check("zero_enable_val", 32'(val()), 32'h0000);
    check("zero_enable_done", 32'(timer_done), 32'd0);

    // rst mid count
    key(4'd5);
    step(3);
    check("rst_mid_pre", 32'(val()), 32'h0005);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    magnetron_on = 1'b0;
    check("rst_mid_val", 32'(val()), 32'h0000);
    check("rst_mid_done", 32'(timer_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- BCD MM:SS countdown timer for the microwave controller.
- Takes keypad digit entry and counts down once per second while the magnetron is on.
- Drives the `timer_done` input of `on_off_logic`, which resets the magnetron latch.
- Also feeds the display digits.

Parameters:
- TICK_DIV, 100, clock cycles per one-second tick (benches use 4).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- clearn  input  1  active-low clear button; same signal as `on_off_logic.clearn`
- load  input  1  one-cycle strobe: `digit_in` is valid
- digit_in  input  4  BCD keypad digit; values 10-15 are ignored
- magnetron_on  input  1  count enable; latch output driven by `on_off_logic` set/reset
- sec_ones  output  4  BCD seconds units
- sec_tens  output  4  BCD seconds tens (0-9 allowed during entry)
- min_ones  output  4  BCD minutes units
- min_tens  output  4  BCD minutes tens
- zero  output  1  1 when all four digits are 0 (combinational from registered digits)
- timer_done  output  1  level; 1 while state is DONE

Behaviour:
- All outputs except `zero` are registered.
- Priority on every edge: rst > clearn low > load > tick.
- Reset: all digits 0, `timer_done` 0, state SETUP, prescaler 0.
- `clearn` low (any state): same effect as reset.
- States: SETUP, COUNTING, DONE.
- Digit entry (SETUP only, `load`=1, `digit_in`<=9): shift left.
  - min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit_in.
  - The old min_tens is discarded.
- `load` in COUNTING is ignored.
- `load` in DONE: digits cleared, then the new digit shifted in (result 00:0d), `timer_done` 0, state SETUP, all on the same edge.
- SETUP -> COUNTING when `magnetron_on`=1 and `zero`=0; prescaler cleared to 0.
- SETUP with `magnetron_on`=1 and `zero`=1: remains in SETUP, `timer_done` stays 0.
- COUNTING prescaler: counts 0..TICK_DIV-1. A tick occurs on the edge where the prescaler equals TICK_DIV-1, i.e. the first decrement lands TICK_DIV cycles after entering COUNTING.
- COUNTING with `magnetron_on`=0: -> SETUP, digits held, prescaler cleared.
  - No decrement that cycle, even if a tick coincides.
  - Resume restarts a full TICK_DIV period.
- Decrement rule (per tick):
  - seconds field (tens:ones) != 00: decrement as 2-digit BCD (e.g. x0 -> (x-1)9, 99 -> 98).
  - seconds = 00 and minutes != 00: minutes decrement as 2-digit BCD (10 -> 09), seconds -> 59.
- Entered seconds > 59 are legal and count down as-is: 01:99 -> 01:98 ... 01:00 -> 00:59.
- The edge whose decrement yields 00:00 also moves state to DONE and sets `timer_done`=1, same edge.
- DONE: digits stay 00:00, `timer_done` stays 1 regardless of `magnetron_on`, until `clearn` low, `load`, or rst.
- No wrap-around: the value never decrements below 00:00.
- Maximum value is 99:99.

Test Plan:
- Reset/clear: assert rst 2 cycles -> all digits 0, `zero`=1, `timer_done`=0. Repeat with `clearn`=0 during COUNTING at 00:05 -> 00:00 next edge, state SETUP.
- Entry: load 1,3,0 -> 01:30. Load 12 -> unchanged. Load 5,5,5,5,7 -> 55:57.
- Countdown, TICK_DIV=4: enter 3, `magnetron_on`=1 -> 00:02 at cycle 4, 00:01 at 8, 00:00 with `timer_done`=1 at 12. `timer_done` holds until `clearn` pulse.
- Borrow: 01:00 -> 00:59 after one tick. 10:00 -> 09:59. 01:99 -> 01:98.
- Pause/ignore: at 00:20, drop `magnetron_on` after 2 cycles into a period -> value held. Load 7 while COUNTING -> ignored. Re-enable -> next decrement 4 cycles later.
- Simultaneous: `magnetron_on` falls on a tick edge -> no decrement. `load` during DONE -> 00:0d, `timer_done` 0. rst mid-count -> 00:00.
